// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for one MAC lane: operand handshake, accumulator control,
// normalize launch and a one-deep result buffer. Optional q_frac config: MAC_QFRAC_CFG_EN.
module mac_seq_ctrl #(
    parameter int unsigned VEC_LEN       = 9,
    parameter int unsigned CNT_W         = 4,
    parameter logic [4:0]  QFRAC_DEFAULT = 5'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             norm_start,
    input  logic             norm_done,
    output logic             norm_ack,
    input  logic [15:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [4:0]       q_frac,
    output logic [CNT_W-1:0] elem_cnt,
    output logic             busy,
`ifdef MAC_QFRAC_CFG_EN
    input  logic             cfg_we,
    input  logic [4:0]       cfg_qfrac,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_NORM  = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              norm_ack_q, norm_ack_d;
    logic              norm_start_q, norm_start_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        norm_ack_d  = 1'b0;
        in_ready    = 1'b0;
        // A drain this cycle frees the buffer; a capture below may refill it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (VEC_LEN == 1) begin
                        state_d = S_NORM;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_NORM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_NORM: begin
                if (norm_done) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (!out_valid_q || out_ready) begin
                    out_data_d  = mac_result;
                    out_valid_d = 1'b1;
                    norm_ack_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        norm_start_d = (state_d == S_NORM) && (state_q != S_NORM);
        busy_d       = (state_d != S_IDLE) || out_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 16'h0000;
            norm_ack_q   <= 1'b0;
            norm_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            norm_ack_q   <= norm_ack_d;
            norm_start_q <= norm_start_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MAC_QFRAC_CFG_EN
    logic [4:0] q_frac_q;

    // Shift only changes between vectors, never under an accumulation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_frac_q <= QFRAC_DEFAULT;
        end else if (cfg_we && (state_q == S_IDLE) && (cnt_q == '0)) begin
            q_frac_q <= cfg_qfrac;
        end
    end

    assign q_frac = q_frac_q;
`else
    assign q_frac = QFRAC_DEFAULT;
`endif

    assign acc_en     = in_valid & in_ready;
    assign acc_clr    = acc_en & (state_q == S_IDLE);
    assign norm_start = norm_start_q;
    assign norm_ack   = norm_ack_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign elem_cnt   = cnt_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: lane A uses VEC_LEN=9, lane B uses VEC_LEN=1.
module tb_mac_seq_ctrl;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- lane A (VEC_LEN = 9) ----------------
    logic        a_in_valid, a_in_ready, a_acc_en, a_acc_clr, a_norm_start, a_norm_done;
    logic        a_norm_ack, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_mac_result, a_out_data;
    logic [4:0]  a_q_frac;
    logic [3:0]  a_elem_cnt;
    logic [1:0]  a_state;
`ifdef MAC_QFRAC_CFG_EN
    logic        a_cfg_we, b_cfg_we;
    logic [4:0]  a_cfg_qfrac, b_cfg_qfrac;
`endif

    // ---------------- lane B (VEC_LEN = 1) ----------------
    logic        b_in_valid, b_in_ready, b_acc_en, b_acc_clr, b_norm_start, b_norm_done;
    logic        b_norm_ack, b_out_valid, b_out_ready, b_busy;
    logic [15:0] b_mac_result, b_out_data;
    logic [4:0]  b_q_frac;
    logic [3:0]  b_elem_cnt;
    logic [1:0]  b_state;

    mac_seq_ctrl #(.VEC_LEN(9), .CNT_W(4), .QFRAC_DEFAULT(5'd0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .acc_en(a_acc_en), .acc_clr(a_acc_clr),
        .norm_start(a_norm_start), .norm_done(a_norm_done), .norm_ack(a_norm_ack),
        .mac_result(a_mac_result),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .q_frac(a_q_frac), .elem_cnt(a_elem_cnt), .busy(a_busy),
`ifdef MAC_QFRAC_CFG_EN
        .cfg_we(a_cfg_we), .cfg_qfrac(a_cfg_qfrac),
`endif
        .dbg_state(a_state)
    );

    mac_seq_ctrl #(.VEC_LEN(1), .CNT_W(4), .QFRAC_DEFAULT(5'd0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .acc_en(b_acc_en), .acc_clr(b_acc_clr),
        .norm_start(b_norm_start), .norm_done(b_norm_done), .norm_ack(b_norm_ack),
        .mac_result(b_mac_result),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .q_frac(b_q_frac), .elem_cnt(b_elem_cnt), .busy(b_busy),
`ifdef MAC_QFRAC_CFG_EN
        .cfg_we(b_cfg_we), .cfg_qfrac(b_cfg_qfrac),
`endif
        .dbg_state(b_state)
    );

    // ---------------- scoreboard / statistics ----------------
    int n_vec, n_err, cyc;
    int a_n_en, a_n_clr, a_n_ns, a_n_ack, a_ns_cyc, a_ov_cyc, a_max_cnt;
    int b_n_en, b_n_clr, b_n_ns, b_max_cnt;
    logic a_ns_s, a_ack_s, b_ns_s, b_ack_s;
    logic [15:0] a_exp_q[$], a_got_q[$], a_res_q[$];
    logic [15:0] b_exp_q[$], b_got_q[$], b_res_q[$];

    task automatic clear_stats();
        cyc = 0;
        a_n_en = 0; a_n_clr = 0; a_n_ns = 0; a_n_ack = 0;
        a_ns_cyc = -1; a_ov_cyc = -1; a_max_cnt = 0;
        b_n_en = 0; b_n_clr = 0; b_n_ns = 0; b_max_cnt = 0;
        a_exp_q.delete(); a_got_q.delete(); a_res_q.delete();
        b_exp_q.delete(); b_got_q.delete(); b_res_q.delete();
    endtask

    // One clock: observe at negedge, then play the datapath role just after posedge.
    // The datapath raises norm_done one cycle after norm_start and holds it until norm_ack.
    task automatic step();
        @(negedge clk);
        if (a_acc_en) a_n_en++;
        if (a_acc_en && a_acc_clr) a_n_clr++;
        if (a_norm_start) begin a_n_ns++; a_ns_cyc = cyc; end
        if (a_norm_ack) a_n_ack++;
        if (a_out_valid && a_ov_cyc < 0) a_ov_cyc = cyc;
        if (a_out_valid && a_out_ready) a_got_q.push_back(a_out_data);
        if (int'(a_elem_cnt) > a_max_cnt) a_max_cnt = int'(a_elem_cnt);
        if (b_acc_en) b_n_en++;
        if (b_acc_en && b_acc_clr) b_n_clr++;
        if (b_norm_start) b_n_ns++;
        if (b_out_valid && b_out_ready) b_got_q.push_back(b_out_data);
        if (int'(b_elem_cnt) > b_max_cnt) b_max_cnt = int'(b_elem_cnt);
        a_ns_s = a_norm_start; a_ack_s = a_norm_ack;
        b_ns_s = b_norm_start; b_ack_s = b_norm_ack;
        @(posedge clk);
        #1;
        cyc++;
        if (a_ack_s) a_norm_done = 1'b0;
        if (a_ns_s) begin
            a_norm_done = 1'b1;
            if (a_res_q.size() > 0) a_mac_result = a_res_q.pop_front();
        end
        if (b_ack_s) b_norm_done = 1'b0;
        if (b_ns_s) begin
            b_norm_done = 1'b1;
            if (b_res_q.size() > 0) b_mac_result = b_res_q.pop_front();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_vec++;
        if (a_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", a_state); end
        n_vec++;
        if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        n_vec++;
        if ({a_acc_en, a_acc_clr, a_norm_start, a_norm_ack, a_out_valid, a_busy} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 000000",
                {a_acc_en, a_acc_clr, a_norm_start, a_norm_ack, a_out_valid, a_busy});
        end
        n_vec++;
        if (a_out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", a_out_data); end
        n_vec++;
        if (a_elem_cnt !== 4'd0 || a_q_frac !== 5'd0) begin
            n_err++; $display("FAIL reset_cnt_qfrac: got %0d/%0d want 0/0", a_elem_cnt, a_q_frac);
        end
        n_vec++;
        if (b_state !== 2'd0 || b_in_ready !== 1'b1 || b_busy !== 1'b0 || b_q_frac !== 5'd0) begin
            n_err++; $display("FAIL reset_lane_b: got st=%0d rdy=%b busy=%b qf=%0d want 0/1/0/0",
                b_state, b_in_ready, b_busy, b_q_frac);
        end

        // Reset in the middle of a vector at elem_cnt = 4.
        a_in_valid = 1'b1;
        repeat (4) step();
        a_in_valid = 1'b0;
        n_vec++;
        if (a_elem_cnt !== 4'd4 || a_state !== 2'd1) begin
            n_err++; $display("FAIL pre_reset_accum: got cnt=%0d st=%0d want 4/1", a_elem_cnt, a_state);
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (a_elem_cnt !== 4'd0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_state !== 2'd0) begin
            n_err++; $display("FAIL async_reset: got cnt=%0d rdy=%b ov=%b st=%0d want 0/1/0/0",
                a_elem_cnt, a_in_ready, a_out_valid, a_state);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        a_in_valid = 1'b1;
        #1;
        n_vec++;
        if (a_acc_en !== 1'b1 || a_acc_clr !== 1'b1) begin
            n_err++; $display("FAIL post_reset_clr: got en=%b clr=%b want 1/1", a_acc_en, a_acc_clr);
        end
        a_in_valid = 1'b0;
        step();
    endtask

    task automatic test_single_vector();
        clear_stats();
        a_out_ready = 1'b1;
        a_res_q.push_back(16'h3C00);
        a_exp_q.push_back(16'h3C00);
        a_in_valid = 1'b1;
        repeat (9) step();
        a_in_valid = 1'b0;
        repeat (7) step();
        n_vec++;
        if (a_n_en != 9) begin n_err++; $display("FAIL sv_acc_en_count: got %0d want 9", a_n_en); end
        n_vec++;
        if (a_n_clr != 1) begin n_err++; $display("FAIL sv_acc_clr_count: got %0d want 1", a_n_clr); end
        n_vec++;
        if (a_n_ns != 1 || a_ns_cyc != 9) begin
            n_err++; $display("FAIL sv_norm_start: got n=%0d cyc=%0d want 1/9", a_n_ns, a_ns_cyc);
        end
        n_vec++;
        if (a_ov_cyc != 12) begin n_err++; $display("FAIL sv_out_latency: got cycle %0d want 12", a_ov_cyc); end
        n_vec++;
        if (a_n_ack != 1) begin n_err++; $display("FAIL sv_norm_ack: got %0d want 1", a_n_ack); end
        n_vec++;
        if (a_max_cnt != 8) begin n_err++; $display("FAIL sv_max_cnt: got %0d want 8", a_max_cnt); end
        n_vec++;
        if (a_busy !== 1'b0) begin n_err++; $display("FAIL sv_busy_end: got %b want 0", a_busy); end
        n_vec++;
        if (a_got_q.size() != a_exp_q.size()) begin
            n_err++; $display("FAIL sv_result_count: got %0d want %0d", a_got_q.size(), a_exp_q.size());
        end else begin
            for (int i = 0; i < a_exp_q.size(); i++) begin
                n_vec++;
                if (a_got_q[i] !== a_exp_q[i]) begin
                    n_err++; $display("FAIL sv_result[%0d]: got %h want %h", i, a_got_q[i], a_exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        a_out_ready = 1'b0;
        a_res_q.push_back(16'h4000); a_exp_q.push_back(16'h4000);
        a_res_q.push_back(16'hC200); a_exp_q.push_back(16'hC200);
        a_in_valid = 1'b1;
        repeat (21) step();
        a_in_valid = 1'b0;
        repeat (6) step();
        n_vec++;
        if (a_n_en != 18 || a_n_clr != 2) begin
            n_err++; $display("FAIL bp_handshakes: got en=%0d clr=%0d want 18/2", a_n_en, a_n_clr);
        end
        n_vec++;
        if (a_state !== 2'd3 || a_in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_wait_capt: got st=%0d rdy=%b want 3/0", a_state, a_in_ready);
        end
        n_vec++;
        if (a_n_ack != 1 || a_norm_ack !== 1'b0) begin
            n_err++; $display("FAIL bp_no_ack: got acks=%0d ack=%b want 1/0", a_n_ack, a_norm_ack);
        end
        n_vec++;
        if (a_out_valid !== 1'b1 || a_out_data !== 16'h4000 || a_busy !== 1'b1) begin
            n_err++; $display("FAIL bp_held_data: got ov=%b data=%h busy=%b want 1/4000/1",
                a_out_valid, a_out_data, a_busy);
        end
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        n_vec++;
        if (a_out_valid !== 1'b1 || a_out_data !== 16'hC200) begin
            n_err++; $display("FAIL bp_reload: got ov=%b data=%h want 1/c200", a_out_valid, a_out_data);
        end
        n_vec++;
        if (a_norm_ack !== 1'b1 || a_state !== 2'd0) begin
            n_err++; $display("FAIL bp_reload_ack: got ack=%b st=%0d want 1/0", a_norm_ack, a_state);
        end
        a_out_ready = 1'b1;
        repeat (3) step();
        n_vec++;
        if (a_got_q.size() != a_exp_q.size()) begin
            n_err++; $display("FAIL bp_result_count: got %0d want %0d", a_got_q.size(), a_exp_q.size());
        end else begin
            for (int i = 0; i < a_exp_q.size(); i++) begin
                n_vec++;
                if (a_got_q[i] !== a_exp_q[i]) begin
                    n_err++; $display("FAIL bp_result[%0d]: got %h want %h", i, a_got_q[i], a_exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        clear_stats();
        b_out_ready = 1'b1;
        b_res_q.push_back(16'h1111); b_exp_q.push_back(16'h1111);
        b_res_q.push_back(16'h2222); b_exp_q.push_back(16'h2222);
        b_res_q.push_back(16'h3333); b_exp_q.push_back(16'h3333);
        for (int i = 0; i < 12; i++) begin
            b_in_valid = (i % 2 == 0);
            step();
        end
        b_in_valid = 1'b0;
        repeat (6) step();
        n_vec++;
        if (b_n_en != 3 || b_n_clr != 3) begin
            n_err++; $display("FAIL gap_acc: got en=%0d clr=%0d want 3/3", b_n_en, b_n_clr);
        end
        n_vec++;
        if (b_n_ns != 3) begin n_err++; $display("FAIL gap_norm_start: got %0d want 3", b_n_ns); end
        n_vec++;
        if (b_max_cnt != 0) begin n_err++; $display("FAIL gap_elem_cnt: got %0d want 0", b_max_cnt); end
        n_vec++;
        if (b_got_q.size() != b_exp_q.size()) begin
            n_err++; $display("FAIL gap_result_count: got %0d want %0d", b_got_q.size(), b_exp_q.size());
        end else begin
            for (int i = 0; i < b_exp_q.size(); i++) begin
                n_vec++;
                if (b_got_q[i] !== b_exp_q[i]) begin
                    n_err++; $display("FAIL gap_result[%0d]: got %h want %h", i, b_got_q[i], b_exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_config();
`ifdef MAC_QFRAC_CFG_EN
        clear_stats();
        a_cfg_we = 1'b1; a_cfg_qfrac = 5'd7;
        step();
        a_cfg_we = 1'b0;
        n_vec++;
        if (a_q_frac !== 5'd7) begin n_err++; $display("FAIL cfg_write_idle: got %0d want 7", a_q_frac); end
        a_out_ready = 1'b1;
        a_res_q.push_back(16'h1234); a_exp_q.push_back(16'h1234);
        a_in_valid = 1'b1;
        repeat (9) step();
        a_in_valid = 1'b0;
        n_vec++;
        if (a_state !== 2'd2) begin n_err++; $display("FAIL cfg_in_norm: got st=%0d want 2", a_state); end
        a_cfg_we = 1'b1; a_cfg_qfrac = 5'd3;
        step();
        a_cfg_we = 1'b0;
        n_vec++;
        if (a_q_frac !== 5'd7) begin n_err++; $display("FAIL cfg_write_norm: got %0d want 7", a_q_frac); end
        repeat (5) step();
        n_vec++;
        if (a_got_q.size() != 1 || a_got_q[0] !== a_exp_q[0]) begin
            n_err++; $display("FAIL cfg_result: got n=%0d want 1 result %h", a_got_q.size(), a_exp_q[0]);
        end
`else
        step();
        n_vec++;
        if (a_q_frac !== 5'd0) begin n_err++; $display("FAIL qfrac_fixed: got %0d want 0", a_q_frac); end
`endif
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_norm_done = 1'b0; a_mac_result = 16'h0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_norm_done = 1'b0; b_mac_result = 16'h0; b_out_ready = 1'b1;
`ifdef MAC_QFRAC_CFG_EN
        a_cfg_we = 1'b0; a_cfg_qfrac = 5'd0;
        b_cfg_we = 1'b0; b_cfg_qfrac = 5'd0;
`endif
        clear_stats();
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_gaps();
        test_config();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
